fft_iterative_radix2: RTL and testbench



---
 rtl/fft_iterative_radix2.sv | 189 ++++++++++++++++++
 tb/tb_fft_iterative_radix2.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iterative_radix2.sv
// Folded radix-2 decimation-in-time FFT.
// A single butterfly is reused across all stages. It works in place on a register array,
// one butterfly per clock.
// Input frames are written in bit-reversed order, so the spectrum comes out in natural order.
// Twiddle factors are fetched combinationally through the tw_idx / tw_real / tw_imag port.
// Optional build macro FFT_STAGE_SCALE_EN halves both butterfly outputs at every stage.
// This gives an overall 1/N scaling.
module fft_iterative_radix2 #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_real [N_SAMPLES],
    input  logic [BIT_WIDTH-1:0] recv_imag [N_SAMPLES],
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_real [N_SAMPLES],
    output logic [BIT_WIDTH-1:0] send_imag [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [(($clog2(N_SAMPLES) > 1) ? $clog2(N_SAMPLES) - 1 : 1)-1:0] tw_idx,
    input  logic [BIT_WIDTH-1:0] tw_real,
    input  logic [BIT_WIDTH-1:0] tw_imag
);

    localparam int L    = $clog2(N_SAMPLES);
    localparam int TW_W = (L > 1) ? L - 1 : 1;
    localparam int KW   = TW_W;
    localparam int SW   = $clog2(L + 1);
    localparam int HALF = N_SAMPLES / 2;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 send_val_q, send_val_d;
    logic [BIT_WIDTH-1:0] re_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] im_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] re_d [N_SAMPLES];
    logic [BIT_WIDTH-1:0] im_d [N_SAMPLES];

    // Butterfly addressing and datapath signals
    logic [L-1:0]         k_ext, span, lo, a_idx, b_idx;
    logic [BIT_WIDTH-1:0] xa_re, xa_im, xb_re, xb_im;
    logic [BIT_WIDTH-1:0] t_re, t_im;
    logic [BIT_WIDTH-1:0] ya_re, ya_im, yb_re, yb_im;
    logic signed [2*BIT_WIDTH-1:0] wr_x, wi_x, xr_x, xi_x;
    logic signed [2*BIT_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
`ifdef FFT_STAGE_SCALE_EN
    logic [BIT_WIDTH:0]   sa_re, sa_im, sb_re, sb_im;
`endif

    // Reverse the low L bits of an index; used for the input load permutation
    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) begin
            r[i] = v[L-1-i];
        end
        return r;
    endfunction

    // Handshake outputs: ready only in IDLE and never while reset is asserted
    assign recv_rdy = reset && (state_q == IDLE);
    assign send_val = send_val_q;

    // The spectrum is presented straight from the working array
    genvar gi;
    generate
        for (gi = 0; gi < N_SAMPLES; gi++) begin : g_out
            assign send_real[gi] = re_q[gi];
            assign send_imag[gi] = im_q[gi];
        end
    endgenerate

    // Butterfly pair addresses and twiddle index for the current (stage, k)
    always_comb begin
        k_ext  = L'(k_q);
        span   = L'(1) << stage_q;
        lo     = k_ext & (span - L'(1));
        a_idx  = ((k_ext >> stage_q) << (stage_q + SW'(1))) + lo;
        b_idx  = a_idx + span;
        tw_idx = TW_W'(lo) << (SW'(L - 1) - stage_q);
    end

    // Complex twiddle multiply and add/subtract
    // Each product is rescaled to Q(DECIMAL_PT) on its own before the partial products are combined.
    always_comb begin
        xa_re = re_q[a_idx];
        xa_im = im_q[a_idx];
        xb_re = re_q[b_idx];
        xb_im = im_q[b_idx];
        wr_x  = {{BIT_WIDTH{tw_real[BIT_WIDTH-1]}}, tw_real};
        wi_x  = {{BIT_WIDTH{tw_imag[BIT_WIDTH-1]}}, tw_imag};
        xr_x  = {{BIT_WIDTH{xb_re[BIT_WIDTH-1]}}, xb_re};
        xi_x  = {{BIT_WIDTH{xb_im[BIT_WIDTH-1]}}, xb_im};
        p_rr  = wr_x * xr_x;
        p_ii  = wi_x * xi_x;
        p_ri  = wr_x * xi_x;
        p_ir  = wi_x * xr_x;
        t_re  = BIT_WIDTH'(p_rr >>> DECIMAL_PT) - BIT_WIDTH'(p_ii >>> DECIMAL_PT);
        t_im  = BIT_WIDTH'(p_ri >>> DECIMAL_PT) + BIT_WIDTH'(p_ir >>> DECIMAL_PT);
`ifdef FFT_STAGE_SCALE_EN
        // One extra bit of headroom so the halving never sees a wrapped sum
        sa_re = {xa_re[BIT_WIDTH-1], xa_re} + {t_re[BIT_WIDTH-1], t_re};
        sa_im = {xa_im[BIT_WIDTH-1], xa_im} + {t_im[BIT_WIDTH-1], t_im};
        sb_re = {xa_re[BIT_WIDTH-1], xa_re} - {t_re[BIT_WIDTH-1], t_re};
        sb_im = {xa_im[BIT_WIDTH-1], xa_im} - {t_im[BIT_WIDTH-1], t_im};
        ya_re = BIT_WIDTH'($signed(sa_re) >>> 1);
        ya_im = BIT_WIDTH'($signed(sa_im) >>> 1);
        yb_re = BIT_WIDTH'($signed(sb_re) >>> 1);
        yb_im = BIT_WIDTH'($signed(sb_im) >>> 1);
`else
        ya_re = xa_re + t_re;
        ya_im = xa_im + t_im;
        yb_re = xa_re - t_re;
        yb_im = xa_im - t_im;
`endif
    end

    // Next-state logic: frame load, butterfly write-back, stage/k sequencing
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            IDLE: begin
                if (recv_val) begin
                    for (int i = 0; i < N_SAMPLES; i++) begin
                        re_d[bitrev(L'(i))] = recv_real[i];
                        im_d[bitrev(L'(i))] = recv_imag[i];
                    end
                    stage_d = '0;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                re_d[a_idx] = ya_re;
                im_d[a_idx] = ya_im;
                re_d[b_idx] = yb_re;
                im_d[b_idx] = yb_im;
                if (k_q == KW'(HALF - 1)) begin
                    k_d = '0;
                    if (stage_q == SW'(L - 1)) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (send_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        send_val_d = (state_d == DONE);
    end

    // State, counters and data array; asynchronous reset clears everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            send_val_q <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            send_val_q <= send_val_d;
            re_q       <= re_d;
            im_q       <= im_d;
        end
    end

endmodule

// File: tb/tb_fft_iterative_radix2.sv
// Directed testbench for fft_iterative_radix2 with N=8, BIT_WIDTH=32, DECIMAL_PT=16.
// Twiddles come from a rounded Q16 table.
// Each scenario task checks its own results inline.
module tb_fft_iterative_radix2;

`ifdef FFT_STAGE_SCALE_EN
    localparam int IMP = 32'h0000_2000;
    localparam int DC0 = 32'h0001_0000;
    localparam int CPK = 32'h0000_8000;
`else
    localparam int IMP = 32'h0001_0000;
    localparam int DC0 = 32'h0008_0000;
    localparam int CPK = 32'h0004_0000;
`endif
    localparam int LAT = 12;
    localparam int TOL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] recv_real [8];
    logic [31:0] recv_imag [8];
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] send_real [8];
    logic [31:0] send_imag [8];
    logic        send_val;
    logic        send_rdy;
    logic [1:0]  tw_idx;
    logic [31:0] tw_real;
    logic [31:0] tw_imag;

    int total = 0;
    int bad   = 0;

    fft_iterative_radix2 #(
        .BIT_WIDTH (32),
        .DECIMAL_PT(16),
        .N_SAMPLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_real(recv_real),
        .recv_imag(recv_imag),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_real(send_real),
        .send_imag(send_imag),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .tw_idx   (tw_idx),
        .tw_real  (tw_real),
        .tw_imag  (tw_imag)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: round(cos(2*pi*k/8)*2^16), -round(sin(2*pi*k/8)*2^16)
    always_comb begin
        tw_real = 32'd0;
        tw_imag = 32'd0;
        case (tw_idx)
            2'd0: begin tw_real = 32'(65536);  tw_imag = 32'(0);      end
            2'd1: begin tw_real = 32'(46341);  tw_imag = 32'(-46341); end
            2'd2: begin tw_real = 32'(0);      tw_imag = 32'(-65536); end
            default: begin tw_real = 32'(-46341); tw_imag = 32'(-46341); end
        endcase
    end

    // Put a test pattern on the input: 0 impulse, 1 DC, 2 cosine
    task automatic load_pattern(input int which);
        int cosv [8];
        cosv = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
        for (int i = 0; i < 8; i++) begin
            recv_imag[i] = 32'd0;
            case (which)
                0: recv_real[i] = (i == 0) ? 32'h0001_0000 : 32'd0;
                1: recv_real[i] = 32'h0001_0000;
                default: recv_real[i] = 32'(cosv[i]);
            endcase
        end
    endtask

    // Raise recv_val and advance past the accept edge
    // recv_val is then left at 'hold'; 'accepted' stays 0 if the block never became ready.
    task automatic start_frame(input bit hold, output bit accepted);
        accepted = 1'b0;
        recv_val = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (recv_rdy === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (accepted) begin
            @(posedge clk); #1;
        end
        recv_val = hold;
    endtask

    // Count edges from the accept edge until send_val rises (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (send_val !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL reset_recv_rdy got=%b want=0", recv_rdy); end
        total++; if (send_val !== 1'b0) begin bad++; $display("FAIL reset_send_val got=%b want=0", send_val); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (send_real[i] !== 32'd0 || send_imag[i] !== 32'd0) begin
                bad++; $display("FAIL reset_out[%0d] got=%h/%h want=0/0", i, send_real[i], send_imag[i]);
            end
        end
        #20 reset = 1'b1;
        @(posedge clk); #1;
        total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_recv_rdy got=%b want=1", recv_rdy); end
        total++; if (send_val !== 1'b0) begin bad++; $display("FAIL post_reset_send_val got=%b want=0", send_val); end
        $display("reset released: recv_rdy=%b send_val=%b", recv_rdy, send_val);
    endtask

    task automatic test_impulse();
        bit acc; int lat; int dr; int di;
        load_pattern(0);
        start_frame(1'b0, acc);
        wait_done(lat);
        $display("frame impulse: accepted=%0d latency=%0d", acc, lat);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL impulse_accept got=%0d want=1", acc); end
        total++; if (lat != LAT) begin bad++; $display("FAIL impulse_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            dr = $signed(send_real[i]) - IMP;
            di = $signed(send_imag[i]);
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL) begin
                bad++; $display("FAIL impulse_re[%0d] got=%h want=%h", i, send_real[i], IMP);
            end
            total++;
            if ($isunknown(send_imag[i]) || di > TOL || di < -TOL) begin
                bad++; $display("FAIL impulse_im[%0d] got=%h want=0", i, send_imag[i]);
            end
        end
        handshake();
        total++; if (send_val !== 1'b0) begin bad++; $display("FAIL impulse_send_val_drop got=%b want=0", send_val); end
        total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL impulse_recv_rdy_back got=%b want=1", recv_rdy); end
    endtask

    task automatic test_dc();
        bit acc; int lat; int dr; int di; int want;
        load_pattern(1);
        start_frame(1'b0, acc);
        wait_done(lat);
        $display("frame dc: accepted=%0d latency=%0d", acc, lat);
        total++; if (acc !== 1'b1 || lat != LAT) begin bad++; $display("FAIL dc_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            want = (i == 0) ? DC0 : 0;
            dr = $signed(send_real[i]) - want;
            di = $signed(send_imag[i]);
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL) begin
                bad++; $display("FAIL dc_re[%0d] got=%h want=%h", i, send_real[i], want);
            end
            total++;
            if ($isunknown(send_imag[i]) || di > TOL || di < -TOL) begin
                bad++; $display("FAIL dc_im[%0d] got=%h want=0", i, send_imag[i]);
            end
        end
        handshake();
    endtask

    task automatic test_cosine();
        bit acc; int lat; int dr; int di; int want;
        load_pattern(2);
        start_frame(1'b0, acc);
        wait_done(lat);
        $display("frame cosine: accepted=%0d latency=%0d", acc, lat);
        total++; if (acc !== 1'b1 || lat != LAT) begin bad++; $display("FAIL cosine_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            want = (i == 1 || i == 7) ? CPK : 0;
            dr = $signed(send_real[i]) - want;
            di = $signed(send_imag[i]);
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL) begin
                bad++; $display("FAIL cosine_re[%0d] got=%h want=%h", i, send_real[i], want);
            end
            total++;
            if ($isunknown(send_imag[i]) || di > TOL || di < -TOL) begin
                bad++; $display("FAIL cosine_im[%0d] got=%h want=0", i, send_imag[i]);
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        bit acc; int lat;
        load_pattern(0);
        start_frame(1'b0, acc);
        wait_done(lat);
        total++; if (acc !== 1'b1 || lat != LAT) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                load_pattern(1);
                recv_val = 1'b1;
            end else begin
                recv_val = 1'b0;
            end
            total++; if (send_val !== 1'b1) begin bad++; $display("FAIL bp_send_val[c%0d] got=%b want=1", c, send_val); end
            total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL bp_recv_rdy[c%0d] got=%b want=0", c, recv_rdy); end
            for (int i = 0; i < 8; i++) begin
                total++;
                if (send_real[i] !== 32'(IMP) || send_imag[i] !== 32'd0) begin
                    bad++; $display("FAIL bp_hold[c%0d][%0d] got=%h/%h want=%h/0", c, i, send_real[i], send_imag[i], IMP);
                end
            end
            @(posedge clk); #1;
        end
        recv_val = 1'b0;
        handshake();
        $display("backpressure released: send_val=%b recv_rdy=%b", send_val, recv_rdy);
        total++; if (send_val !== 1'b0) begin bad++; $display("FAIL bp_send_val_drop got=%b want=0", send_val); end
        total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL bp_recv_rdy_back got=%b want=1", recv_rdy); end
        @(posedge clk); #1;
        total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL bp_pulse_ignored got=%b want=1", recv_rdy); end
    endtask

    task automatic test_reset_mid();
        bit acc; int lat; int dr;
        load_pattern(0);
        start_frame(1'b0, acc);
        repeat (4) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        $display("reset asserted mid-compute: send_val=%b recv_rdy=%b", send_val, recv_rdy);
        total++; if (send_val !== 1'b0) begin bad++; $display("FAIL midrst_send_val got=%b want=0", send_val); end
        total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL midrst_recv_rdy got=%b want=0", recv_rdy); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (send_real[i] !== 32'd0 || send_imag[i] !== 32'd0) begin
                bad++; $display("FAIL midrst_out[%0d] got=%h/%h want=0/0", i, send_real[i], send_imag[i]);
            end
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        total++; if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            bad++; $display("FAIL midrst_idle got=rdy%b/val%b want=rdy1/val0", recv_rdy, send_val);
        end
        load_pattern(0);
        start_frame(1'b0, acc);
        wait_done(lat);
        $display("frame impulse after reset: accepted=%0d latency=%0d", acc, lat);
        total++; if (acc !== 1'b1 || lat != LAT) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            dr = $signed(send_real[i]) - IMP;
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL || send_imag[i] !== 32'd0) begin
                bad++; $display("FAIL midrst_bin[%0d] got=%h/%h want=%h/0", i, send_real[i], send_imag[i], IMP);
            end
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit acc; int lat; int dr; int want;
        load_pattern(0);
        start_frame(1'b1, acc);
        load_pattern(1);
        wait_done(lat);
        $display("frame b2b impulse: accepted=%0d latency=%0d", acc, lat);
        total++; if (acc !== 1'b1 || lat != LAT) begin bad++; $display("FAIL b2b1_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            dr = $signed(send_real[i]) - IMP;
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL || send_imag[i] !== 32'd0) begin
                bad++; $display("FAIL b2b1_bin[%0d] got=%h/%h want=%h/0", i, send_real[i], send_imag[i], IMP);
            end
        end
        handshake();
        total++; if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got=rdy%b/val%b want=rdy1/val0", recv_rdy, send_val);
        end
        @(posedge clk); #1;
        recv_val = 1'b0;
        total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=rdy%b want=0", recv_rdy); end
        wait_done(lat);
        $display("frame b2b dc: latency=%0d", lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL b2b2_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 8; i++) begin
            want = (i == 0) ? DC0 : 0;
            dr = $signed(send_real[i]) - want;
            total++;
            if ($isunknown(send_real[i]) || dr > TOL || dr < -TOL || send_imag[i] !== 32'd0) begin
                bad++; $display("FAIL b2b2_bin[%0d] got=%h/%h want=%h/0", i, send_real[i], send_imag[i], want);
            end
        end
        handshake();
    endtask

    initial begin
        reset    = 1'b0;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            recv_real[i] = 32'd0;
            recv_imag[i] = 32'd0;
        end
        test_reset();
        test_impulse();
        test_dc();
        test_cosine();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
